// File: rtl/adc_ch_averager.sv
// adc_ch_averager
//   Per-channel boxcar averager for a multiplexed ADC sample stream.
//   Each channel accumulates 2^AVG_LOG2 accepted samples. The sample that
//   completes a block produces one result: the block sum shifted right by
//   AVG_LOG2 (floor). Results leave through a valid/ready holding register.
//
// Ports
//   clock         single clock for all logic
//   reset         synchronous, active-high; wins over clear and handshakes
//   sample_valid  upstream sample present
//   sample_ch     channel index of the presented sample (3 bits)
//   sample_data   unsigned conversion result (DATA_W bits)
//   sample_ready  sample is taken this cycle when sample_valid is also high
//   clear         synchronous flush of all accumulation and pending result
//   avg_valid     averaged result held on avg_ch / avg_data
//   avg_ch        channel of the held result
//   avg_data      averaged value
//   avg_ready     downstream accepts the held result
//   busy_mask     bit n set while channel n holds a partial block
module adc_ch_averager #(
   parameter int DATA_W   = 12,
   parameter int AVG_LOG2 = 4,
   parameter int NUM_CH   = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [2:0]        sample_ch,
   input  logic [DATA_W-1:0] sample_data,
   output logic              sample_ready,
   input  logic              clear,
   output logic              avg_valid,
   output logic [2:0]        avg_ch,
   output logic [DATA_W-1:0] avg_data,
   input  logic              avg_ready,
   output logic [NUM_CH-1:0] busy_mask
);

   // The accumulator carries AVG_LOG2 guard bits so a full block of
   // full-scale samples cannot overflow. A one-bit counter is kept when
   // AVG_LOG2 is 0; it then stays at zero and every sample completes.
   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   function automatic logic [DATA_W-1:0] trunc_avg(input logic [ACC_W-1:0] sum);
      return DATA_W'(sum >> AVG_LOG2);
   endfunction

   logic [ACC_W-1:0]  acc     [NUM_CH];
   logic [CNT_W-1:0]  cnt     [NUM_CH];
   logic [ACC_W-1:0]  acc_nxt [NUM_CH];
   logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
   logic [NUM_CH-1:0] busy_nxt;

   logic              accept_p0;
   logic              complete_p0;
   logic [ACC_W-1:0]  sum_p0;

   // Input is only stalled by clear or by a result that cannot leave.
   assign sample_ready = !clear && !(avg_valid && !avg_ready);
   assign accept_p0    = sample_valid && sample_ready;
   assign sum_p0       = acc[sample_ch] + ACC_W'(sample_data);
   assign complete_p0  = accept_p0 && (cnt[sample_ch] == CNT_LAST);

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         acc_nxt[i] = acc[i];
         cnt_nxt[i] = cnt[i];
      end
      if (accept_p0) begin
         if (complete_p0) begin
            acc_nxt[sample_ch] = '0;
            cnt_nxt[sample_ch] = '0;
         end else begin
            acc_nxt[sample_ch] = sum_p0;
            cnt_nxt[sample_ch] = cnt[sample_ch] + CNT_W'(1);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         busy_nxt[i] = (cnt_nxt[i] != '0);
      end
   end

   // p0 -> result register
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
            cnt[i] <= '0;
         end
         avg_valid <= 1'b0;
         avg_ch    <= '0;
         avg_data  <= '0;
         busy_mask <= '0;
      end else if (clear) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
            cnt[i] <= '0;
         end
         avg_valid <= 1'b0;
         busy_mask <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= acc_nxt[i];
            cnt[i] <= cnt_nxt[i];
         end
         busy_mask <= busy_nxt;
         // A completing accept can only occur when the holding register is
         // empty or being drained this cycle, so loading it never drops data.
         if (complete_p0) begin
            avg_valid <= 1'b1;
            avg_ch    <= sample_ch;
            avg_data  <= trunc_avg(sum_p0);
         end else if (avg_ready) begin
            avg_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adc_ch_averager.sv
module tb_adc_ch_averager;

   localparam int DATA_W   = 12;
   localparam int AVG_LOG2 = 4;
   localparam int NUM_CH   = 8;
   localparam int N        = 1 << AVG_LOG2;

   logic              clock = 1'b0;
   logic              reset;
   logic              sample_valid;
   logic [2:0]        sample_ch;
   logic [DATA_W-1:0] sample_data;
   logic              sample_ready;
   logic              clear;
   logic              avg_valid;
   logic [2:0]        avg_ch;
   logic [DATA_W-1:0] avg_data;
   logic              avg_ready;
   logic [NUM_CH-1:0] busy_mask;

   adc_ch_averager #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2), .NUM_CH(NUM_CH)) dut (
      .clock(clock), .reset(reset),
      .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
      .sample_ready(sample_ready), .clear(clear),
      .avg_valid(avg_valid), .avg_ch(avg_ch), .avg_data(avg_data),
      .avg_ready(avg_ready), .busy_mask(busy_mask)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: per-channel list of samples in the current block.
   int model_q [NUM_CH][$];
   int exp_ch[$], exp_data[$];
   int got_ch[$], got_data[$];

   // Record every result transferred to the downstream side.
   always @(negedge clock) begin
      if (reset === 1'b0 && avg_valid === 1'b1 && avg_ready === 1'b1) begin
         got_ch.push_back(int'(avg_ch));
         got_data.push_back(int'(avg_data));
      end
   end

   task automatic model_flush();
      for (int c = 0; c < NUM_CH; c++) model_q[c].delete();
   endtask

   task automatic model_accept(input int ch, input int d);
      int sum;
      model_q[ch].push_back(d);
      if (model_q[ch].size() == N) begin
         sum = 0;
         foreach (model_q[ch][k]) sum += model_q[ch][k];
         exp_ch.push_back(ch);
         exp_data.push_back(sum / N);
         model_q[ch].delete();
      end
   endtask

   function automatic logic [NUM_CH-1:0] model_busy();
      logic [NUM_CH-1:0] m;
      for (int c = 0; c < NUM_CH; c++) m[c] = (model_q[c].size() != 0);
      return m;
   endfunction

   task automatic clear_scoreboard();
      exp_ch.delete(); exp_data.delete();
      got_ch.delete(); got_data.delete();
   endtask

   task automatic drain();
      avg_ready = 1'b1;
      repeat (4) @(posedge clock);
      #1;
   endtask

   // Present one sample until accepted (bounded), then update the model.
   task automatic send(input int ch, input int d, input bit rand_ready);
      bit took, ok;
      ok = 1'b0;
      sample_valid = 1'b1;
      sample_ch    = 3'(ch);
      sample_data  = DATA_W'(d);
      for (int w = 0; w < 100; w++) begin
         if (rand_ready) avg_ready = ($urandom_range(0, 3) != 0);
         @(negedge clock);
         took = sample_ready;
         @(posedge clock);
         #1;
         if (took) begin ok = 1'b1; break; end
      end
      sample_valid = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL send_timeout ch=%0d: accepted=0 required=1", ch);
      end else begin
         model_accept(ch, d);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; clear = 1'b0; sample_valid = 1'b0; sample_ch = '0;
      sample_data = '0; avg_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      model_flush();
      @(negedge clock);
      n_checks++; if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_avg_valid: got %b want 0", avg_valid); end
      n_checks++; if (avg_data !== '0) begin n_fail++; $display("FAIL reset_avg_data: got %0d want 0", avg_data); end
      n_checks++; if (avg_ch !== 3'd0) begin n_fail++; $display("FAIL reset_avg_ch: got %0d want 0", avg_ch); end
      n_checks++; if (busy_mask !== 8'h00) begin n_fail++; $display("FAIL reset_busy: got %h want 00", busy_mask); end
      n_checks++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL reset_sample_ready: got %b want 1", sample_ready); end
      @(posedge clock);
      #1;
   endtask

   task automatic test_single_channel();
      clear_scoreboard();
      avg_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         send(2, 100, 1'b0);
         if (i < N - 1) begin
            n_checks++;
            if (busy_mask !== model_busy()) begin
               n_fail++; $display("FAIL single_busy[%0d]: got %h want %h", i, busy_mask, model_busy());
            end
         end
      end
      n_checks++; if (avg_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", avg_valid); end
      n_checks++; if (avg_ch !== 3'd2) begin n_fail++; $display("FAIL single_ch: got %0d want 2", avg_ch); end
      n_checks++; if (avg_data !== 12'd100) begin n_fail++; $display("FAIL single_data: got %0d want 100", avg_data); end
      n_checks++; if (busy_mask !== 8'h00) begin n_fail++; $display("FAIL single_busy_end: got %h want 00", busy_mask); end
      @(posedge clock);
      #1;
      n_checks++; if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b want 0", avg_valid); end
      drain();
      n_checks++;
      if (got_data.size() != 1 || exp_data.size() != 1) begin
         n_fail++; $display("FAIL single_count: got %0d want 1", got_data.size());
      end else if (got_ch[0] != exp_ch[0] || got_data[0] != exp_data[0]) begin
         n_fail++; $display("FAIL single_result: got ch%0d=%0d want ch%0d=%0d", got_ch[0], got_data[0], exp_ch[0], exp_data[0]);
      end
   endtask

   task automatic test_truncation_fullscale();
      clear_scoreboard();
      avg_ready = 1'b1;
      for (int i = 0; i < N; i++) send(0, (i < N / 2) ? 1 : 2, 1'b0);
      n_checks++; if (avg_ch !== 3'd0 || avg_data !== 12'd1) begin n_fail++; $display("FAIL trunc_result: got ch%0d=%0d want ch0=1", avg_ch, avg_data); end
      for (int i = 0; i < N; i++) send(7, 4095, 1'b0);
      n_checks++; if (avg_ch !== 3'd7 || avg_data !== 12'd4095) begin n_fail++; $display("FAIL fullscale_result: got ch%0d=%0d want ch7=4095", avg_ch, avg_data); end
      drain();
      n_checks++;
      if (got_data.size() != exp_data.size()) begin
         n_fail++; $display("FAIL trunc_count: got %0d want %0d", got_data.size(), exp_data.size());
      end else begin
         foreach (got_data[k]) begin
            n_checks++;
            if (got_ch[k] != exp_ch[k] || got_data[k] != exp_data[k]) begin
               n_fail++; $display("FAIL trunc_seq[%0d]: got ch%0d=%0d want ch%0d=%0d", k, got_ch[k], got_data[k], exp_ch[k], exp_data[k]);
            end
         end
      end
   endtask

   task automatic test_interleave_backpressure();
      clear_scoreboard();
      avg_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         send(1, 10, 1'b0);
         if (i < N - 1) send(5, 3000, 1'b0);
      end
      sample_valid = 1'b1; sample_ch = 3'd5; sample_data = 12'd3000;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         n_checks++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b want 0", k, sample_ready); end
         n_checks++;
         if (avg_valid !== 1'b1 || avg_ch !== 3'd1 || avg_data !== 12'd10) begin
            n_fail++; $display("FAIL hold_result[%0d]: got v%b ch%0d=%0d want v1 ch1=10", k, avg_valid, avg_ch, avg_data);
         end
         @(posedge clock);
         #1;
      end
      avg_ready = 1'b1;
      @(negedge clock);
      n_checks++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", sample_ready); end
      @(posedge clock);
      #1;
      model_accept(5, 3000);
      sample_valid = 1'b0;
      n_checks++;
      if (avg_valid !== 1'b1 || avg_ch !== 3'd5 || avg_data !== 12'd3000) begin
         n_fail++; $display("FAIL back_to_back: got v%b ch%0d=%0d want v1 ch5=3000", avg_valid, avg_ch, avg_data);
      end
      drain();
      n_checks++;
      if (got_data.size() != 2 || exp_data.size() != 2) begin
         n_fail++; $display("FAIL interleave_count: got %0d want 2", got_data.size());
      end else begin
         foreach (got_data[k]) begin
            n_checks++;
            if (got_ch[k] != exp_ch[k] || got_data[k] != exp_data[k]) begin
               n_fail++; $display("FAIL interleave_seq[%0d]: got ch%0d=%0d want ch%0d=%0d", k, got_ch[k], got_data[k], exp_ch[k], exp_data[k]);
            end
         end
      end
   endtask

   task automatic test_clear();
      clear_scoreboard();
      avg_ready = 1'b1;
      for (int i = 0; i < 10; i++) send(3, 4000, 1'b0);
      n_checks++; if (busy_mask !== 8'h08) begin n_fail++; $display("FAIL clear_busy_before: got %h want 08", busy_mask); end
      clear = 1'b1;
      sample_valid = 1'b1; sample_ch = 3'd3; sample_data = 12'd4000;
      @(negedge clock);
      n_checks++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready: got %b want 0", sample_ready); end
      @(posedge clock);
      #1;
      clear = 1'b0; sample_valid = 1'b0;
      model_flush();
      n_checks++; if (busy_mask !== 8'h00 || avg_valid !== 1'b0) begin n_fail++; $display("FAIL clear_state: got busy %h v%b want 00 v0", busy_mask, avg_valid); end
      for (int i = 0; i < N; i++) send(3, 50, 1'b0);
      drain();
      n_checks++;
      if (got_data.size() != 1) begin
         n_fail++; $display("FAIL clear_count: got %0d want 1", got_data.size());
      end else if (got_ch[0] != 3 || got_data[0] != 50) begin
         n_fail++; $display("FAIL clear_result: got ch%0d=%0d want ch3=50", got_ch[0], got_data[0]);
      end
   endtask

   task automatic test_reset_midrun();
      clear_scoreboard();
      avg_ready = 1'b1;
      for (int i = 0; i < N - 1; i++) send(4, int'($urandom_range(0, 4095)), 1'b0);
      n_checks++; if (busy_mask !== 8'h10) begin n_fail++; $display("FAIL rst_mid_busy: got %h want 10", busy_mask); end
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      model_flush();
      n_checks++; if (busy_mask !== 8'h00 || avg_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: got busy %h v%b want 00 v0", busy_mask, avg_valid); end
      for (int i = 0; i < N; i++) send(4, 7, 1'b0);
      drain();
      n_checks++;
      if (got_data.size() != 1) begin
         n_fail++; $display("FAIL rst_mid_count: got %0d want 1", got_data.size());
      end else if (got_ch[0] != 4 || got_data[0] != 7) begin
         n_fail++; $display("FAIL rst_mid_result: got ch%0d=%0d want ch4=7", got_ch[0], got_data[0]);
      end
   endtask

   task automatic test_random();
      clear_scoreboard();
      for (int i = 0; i < 400; i++) begin
         send(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 4095)), 1'b1);
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clock);
            #1;
         end
      end
      drain();
      n_checks++;
      if (busy_mask !== model_busy()) begin n_fail++; $display("FAIL random_busy: got %h want %h", busy_mask, model_busy()); end
      n_checks++;
      if (got_data.size() != exp_data.size()) begin
         n_fail++; $display("FAIL random_count: got %0d want %0d", got_data.size(), exp_data.size());
      end else begin
         foreach (got_data[k]) begin
            n_checks++;
            if (got_ch[k] != exp_ch[k] || got_data[k] != exp_data[k]) begin
               n_fail++; $display("FAIL random_seq[%0d]: got ch%0d=%0d want ch%0d=%0d", k, got_ch[k], got_data[k], exp_ch[k], exp_data[k]);
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_channel();
      test_truncation_fullscale();
      test_interleave_backpressure();
      test_clear();
      test_reset_midrun();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_ch_averager.md
ADC_CH_AVERAGER -- requirements
Module: adc_ch_averager

Interface
REQ-001 SHALL have parameter DATA_W, default 12, sample and result width.
REQ-002 SHALL have parameter AVG_LOG2, default 4, log2 of samples averaged per result; legal range 0..8.
REQ-003 SHALL have parameter NUM_CH, default 8, channel count, fixed with 3-bit channel index.
REQ-004 clock  in  1  single clock for all logic.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sample_valid  in  1  upstream sample present; sample stream is {channel, 12-bit conversion} from the LTC2308 FIFO stage.
REQ-007 sample_ch  in  3  channel of the presented sample.
REQ-008 sample_data  in  DATA_W  unsigned conversion result.
REQ-009 sample_ready  out  1  block accepts the sample this cycle.
REQ-010 clear  in  1  synchronous flush of all accumulation state.
REQ-011 avg_valid  out  1  averaged result held on avg_ch/avg_data.
REQ-012 avg_ch  out  3  channel of the result.
REQ-013 avg_data  out  DATA_W  averaged value.
REQ-014 avg_ready  in  1  downstream accepts the result.
REQ-015 busy_mask  out  NUM_CH  bit n high when channel n holds a partial accumulation (count != 0).

Function
REQ-016 Sample accepted iff sample_valid && sample_ready at a rising clock edge.
REQ-017 sample_ready = !clear && !(avg_valid && !avg_ready); no other condition stalls input.
REQ-018 Per channel: accumulator of DATA_W+AVG_LOG2 bits, sample counter of AVG_LOG2 bits; full-scale sum never overflows.
REQ-019 On accept with counter < 2^AVG_LOG2-1: acc[ch] <= acc[ch]+sample_data, cnt[ch] <= cnt[ch]+1; no output change.
REQ-020 On accept with counter = 2^AVG_LOG2-1 (completing sample): avg_data <= (acc[ch]+sample_data) >> AVG_LOG2 (floor truncation, no rounding), avg_ch <= ch, avg_valid <= 1, acc[ch] <= 0, cnt[ch] <= 0.
REQ-021 Latency: avg_valid rises the cycle after the completing sample is accepted (one register stage).
REQ-022 AVG_LOG2 = 0: every accepted sample is a completing sample; avg_data equals sample_data one cycle later.
REQ-023 Result handshake: avg_valid, avg_ch, avg_data SHALL hold stable while avg_valid && !avg_ready.
REQ-024 avg_valid && avg_ready with no completing accept same cycle: avg_valid <= 0 next cycle.
REQ-025 avg_valid && avg_ready with a completing accept same cycle: new result loaded, avg_valid stays 1; back-to-back results at one per cycle SHALL be supported.
REQ-026 Channels independent: interleaved samples on different channels SHALL accumulate separately without cross-contamination.
REQ-027 clear: next cycle all acc and cnt = 0, avg_valid = 0, busy_mask = 0; any sample presented in the clear cycle is not accepted (sample_ready low); pending result discarded.
REQ-028 busy_mask is registered, derived from cnt values after each edge.

Reset
REQ-029 reset has priority over clear and all handshakes.
REQ-030 On reset: all acc and cnt = 0, avg_valid = 0, avg_ch = 0, avg_data = 0, busy_mask = 0; sample_ready = 1 in the cycle after reset deasserts.
REQ-031 Reset asserted mid-accumulation or while a result is held discards all state; no result emitted.

Verification
REQ-032 Reset: assert 2 cycles -> avg_valid=0, avg_data=0, avg_ch=0, busy_mask=0x00, sample_ready=1.
REQ-033 16 samples ch2 value 100, avg_ready=1 -> busy_mask[2] high after first, one cycle after 16th accept avg_valid=1, avg_ch=2, avg_data=100, busy_mask=0x00.
REQ-034 Truncation/full scale: ch0 8x1 + 8x2 -> avg_data=1; ch7 16x4095 -> avg_data=4095 (sum 65520, no overflow).
REQ-035 Interleave ch1 (value 10) / ch5 (value 3000), 32 samples, avg_ready=0 at first result -> sample_ready=0, avg_ch=1/avg_data=10 stable until avg_ready=1, then ch5 result 3000 follows; no sample lost.
REQ-036 Clear mid-run: 10 samples ch3 value 4000, clear 1 cycle (sample offered that cycle ignored), then 16 samples ch3 value 50 -> single result avg_data=50.
REQ-037 Reset mid-run: 15 samples ch4, reset, 16 samples ch4 value 7 -> exactly one result avg_data=7.
